// File: rtl/spi_pkg.sv
// Shared types for the SPI slave serial engine: FSM states, SPI mode encoding,
// default word length.
package spi_pkg;

    localparam int SPI_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_state_e;

    // {cpol, cpha}
    typedef enum logic [1:0] {
        MODE0 = 2'b00,
        MODE1 = 2'b01,
        MODE2 = 2'b10,
        MODE3 = 2'b11
    } spi_mode_e;

endpackage

// File: rtl/spi_sync_edge.sv
// Synchronizes the external SCLK/CS_N/MOSI pins into clk_i and turns SCLK and
// CS_N transitions into single-cycle pulses.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic sclk,
    input  logic cs_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise,
    output logic mosi_sync
);

    logic [SYNC_STAGES-1:0] sclk_sr, cs_sr, mosi_sr;
    logic                   sclk_prev, cs_prev;

    // MOSI goes through the same depth as SCLK so the sampled bit lines up with the edge pulse.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sclk_sr   <= '0;
            cs_sr     <= '1;
            mosi_sr   <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b1;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            cs_sr     <= {cs_sr[SYNC_STAGES-2:0], cs_n};
            mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sr[SYNC_STAGES-1];
            cs_prev   <= cs_sr[SYNC_STAGES-1];
        end
    end

    assign sclk_rise = !sclk_prev &  sclk_sr[SYNC_STAGES-1];
    assign sclk_fall =  sclk_prev & !sclk_sr[SYNC_STAGES-1];
    assign cs_fall   =  cs_prev   & !cs_sr[SYNC_STAGES-1];
    assign cs_rise   = !cs_prev   &  cs_sr[SYNC_STAGES-1];
    assign mosi_sync = mosi_sr[SYNC_STAGES-1];

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave serial engine: oversampled SCLK, full-duplex words, valid/ready TX/RX.
// Define SPI_SLAVE_RX_OVERRUN_EN to add rx_rdy_i backpressure and rx_overrun_o.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int DATA_W      = SPI_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              spi_sclk_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_mosi_i,
    output logic              spi_miso_o,
    output logic              spi_miso_oe_o,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              lsb_first_i,
    input  logic [DATA_W-1:0] tx_data_i,
    input  logic              tx_vld_i,
    output logic              tx_rdy_o,
    output logic [DATA_W-1:0] rx_data_o,
    output logic              rx_vld_o,
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    input  logic              rx_rdy_i,
    output logic              rx_overrun_o,
`endif
    output logic              busy_o,
    output logic              tx_underrun_o
);

    localparam int CNT_W = $clog2(DATA_W);

    spi_state_e        state, state_nxt;
    spi_mode_e         mode_q;
    logic              lsb_q;
    logic              cpol, cpha;
    logic              sclk_rise, sclk_fall, cs_fall, cs_rise, mosi;
    logic              smp, shf, in_shift, last, word_done, do_load, tx_wr;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] tx_sh, rx_sh, rx_nxt, hold;
    logic              hold_full, load_pend, under_pend, drive;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .sclk      (spi_sclk_i),
        .cs_n      (spi_cs_n_i),
        .mosi      (spi_mosi_i),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise),
        .mosi_sync (mosi)
    );

    assign cpol = mode_q[1];
    assign cpha = mode_q[0];

    // Leading edge leaves the idle level; CPHA picks which edge samples.
    assign smp = cpha ? (cpol ? sclk_rise : sclk_fall) : (cpol ? sclk_fall : sclk_rise);
    assign shf = cpha ? (cpol ? sclk_fall : sclk_rise) : (cpol ? sclk_rise : sclk_fall);

    assign in_shift  = (state == SHIFT) && !cs_rise;
    assign last      = (bit_cnt == CNT_W'(DATA_W-1));
    assign word_done = in_shift && smp && last;
    assign do_load   = ((state == LOAD) && !cs_rise) || (word_done && !cpha) ||
                       (in_shift && shf && load_pend);
    assign tx_wr     = tx_vld_i && tx_rdy_o;
    assign rx_nxt    = lsb_q ? {mosi, rx_sh[DATA_W-1:1]} : {rx_sh[DATA_W-2:0], mosi};

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall) state_nxt = LOAD;
            LOAD:    state_nxt = cs_rise ? IDLE : SHIFT;
            SHIFT:   if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mode_q        <= MODE0;
            lsb_q         <= 1'b0;
            bit_cnt       <= '0;
            tx_sh         <= '0;
            rx_sh         <= '0;
            hold          <= '0;
            hold_full     <= 1'b0;
            load_pend     <= 1'b0;
            under_pend    <= 1'b0;
            drive         <= 1'b0;
            rx_data_o     <= '0;
            rx_vld_o      <= 1'b0;
            tx_underrun_o <= 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
            rx_overrun_o  <= 1'b0;
`endif
        end else begin
            tx_underrun_o <= 1'b0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
            rx_overrun_o  <= word_done && rx_vld_o && !rx_rdy_i;
            if (word_done)     rx_vld_o <= 1'b1;
            else if (rx_rdy_i) rx_vld_o <= 1'b0;
`else
            rx_vld_o      <= word_done;
`endif
            if (state == IDLE && cs_fall) begin
                mode_q <= spi_mode_e'({cpol_i, cpha_i});
                lsb_q  <= lsb_first_i;
            end
            if (tx_wr) begin
                hold      <= tx_data_i;
                hold_full <= 1'b1;
            end
            if (in_shift && smp) begin
                rx_sh   <= rx_nxt;
                bit_cnt <= last ? '0 : bit_cnt + 1'b1;
                if (last) begin
                    rx_data_o <= rx_nxt;
                    load_pend <= cpha;
                end
                if (under_pend) begin
                    tx_underrun_o <= 1'b1;
                    under_pend    <= 1'b0;
                end
            end
            if (in_shift && shf && !load_pend) begin
                if (bit_cnt != '0)
                    tx_sh <= lsb_q ? {1'b0, tx_sh[DATA_W-1:1]} : {tx_sh[DATA_W-2:0], 1'b0};
                drive <= 1'b1;
            end
            if (do_load) begin
                tx_sh     <= hold_full ? hold : '0;
                hold_full <= tx_wr;
                load_pend <= 1'b0;
                drive     <= (state == SHIFT) || !cpha;
                // A CPHA=0 reload precedes any commitment to another word, so its
                // underrun is reported only once that word's first bit is sampled.
                if (!hold_full) begin
                    if (state == SHIFT && !cpha) under_pend    <= 1'b1;
                    else                         tx_underrun_o <= 1'b1;
                end
            end
            if (state != IDLE && cs_rise) begin
                bit_cnt    <= '0;
                tx_sh      <= '0;
                rx_sh      <= '0;
                load_pend  <= 1'b0;
                under_pend <= 1'b0;
                drive      <= 1'b0;
            end
        end
    end

    assign tx_rdy_o      = !hold_full;
    assign busy_o        = (state != IDLE);
    assign spi_miso_oe_o = busy_o;
    assign spi_miso_o    = busy_o && drive && (lsb_q ? tx_sh[0] : tx_sh[DATA_W-1]);

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: a behavioural SPI master drives frames and
// every result is compared against hand-computed constants.
module tb_spi_slave_if;

    localparam int H = 8;  // SCLK half-period in clk cycles

    logic       clk, rstn, sclk, cs_n, mosi, cpol, cpha, lsb, tx_vld;
    logic [7:0] tx_data;
    logic       miso, miso_oe, tx_rdy, rx_vld, busy, under;
    logic [7:0] rx_data;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
    logic       rx_rdy, rx_ovr;
    int         n_ovr = 0;
`endif

    int         n_chk = 0, n_pass = 0;
    int         n_rxv = 0, n_under = 0, rx_idx = 0, base_un;
    logic [7:0] rx_log [64];
    logic [7:0] m0, m1;

    spi_slave_if #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk_i         (clk),
        .rstn_i        (rstn),
        .spi_sclk_i    (sclk),
        .spi_cs_n_i    (cs_n),
        .spi_mosi_i    (mosi),
        .spi_miso_o    (miso),
        .spi_miso_oe_o (miso_oe),
        .cpol_i        (cpol),
        .cpha_i        (cpha),
        .lsb_first_i   (lsb),
        .tx_data_i     (tx_data),
        .tx_vld_i      (tx_vld),
        .tx_rdy_o      (tx_rdy),
        .rx_data_o     (rx_data),
        .rx_vld_o      (rx_vld),
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        .rx_rdy_i      (rx_rdy),
        .rx_overrun_o  (rx_ovr),
`endif
        .busy_o        (busy),
        .tx_underrun_o (under)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_vld) begin
            if (n_rxv < 64) rx_log[n_rxv] <= rx_data;
            n_rxv <= n_rxv + 1;
        end
        if (under) n_under <= n_under + 1;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        if (rx_ovr) n_ovr <= n_ovr + 1;
`endif
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start(input logic p, input logic h, input logic l);
        cpol = p; cpha = h; lsb = l; sclk = p;
        wait_n(H);
        cs_n = 1'b0;
        wait_n(H);
    endtask

    task automatic frame_end();
        wait_n(H);
        cs_n = 1'b1;
        wait_n(2*H);
    endtask

    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            int idx;
            idx = lsb ? i : 7 - i;
            if (!cpha) begin
                mosi = tx[idx];
                wait_n(H);
                sclk = !cpol;
                rx[idx] = miso;
                wait_n(H);
                sclk = cpol;
            end else begin
                sclk = !cpol;
                mosi = tx[idx];
                wait_n(H);
                sclk = cpol;
                rx[idx] = miso;
                wait_n(H);
            end
        end
    endtask

    task automatic tx_write(input logic [7:0] d);
        chk("tx_rdy_before_write", tx_rdy, 1);
        tx_data = d;
        tx_vld  = 1'b1;
        @(negedge clk);
        tx_vld  = 1'b0;
        chk("tx_rdy_after_write", tx_rdy, 0);
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] exp);
        chk(tag, rx_log[rx_idx], exp);
        rx_idx++;
    endtask

    initial begin
        rstn = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; tx_vld = 1'b0; tx_data = '0;
`ifdef SPI_SLAVE_RX_OVERRUN_EN
        rx_rdy = 1'b1;
`endif
        wait_n(3);
        chk("rst_miso", miso, 0);
        chk("rst_oe", miso_oe, 0);
        chk("rst_tx_rdy", tx_rdy, 1);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_rx_vld", rx_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_underrun", under, 0);
        rstn = 1'b1;
        wait_n(4);

        // mode 0, MSB first, preloaded A5, master sends 3C
        base_un = n_under;
        tx_write(8'hA5);
        frame_start(1'b0, 1'b0, 1'b0);
        chk("m0_busy", busy, 1);
        chk("m0_oe", miso_oe, 1);
        chk("m0_tx_rdy_after_load", tx_rdy, 1);
        xfer(8'h3C, 8, m0);
        frame_end();
        chk("m0_rx_cnt", n_rxv, 1);
        expect_rx("m0_rx", 8'h3C);
        chk("m0_master_rx", m0, 8'hA5);
        chk("m0_underrun", n_under - base_un, 0);
        chk("m0_idle_busy", busy, 0);
        chk("m0_idle_miso", miso, 0);

        // mode 3, LSB first, back-to-back words, second TX word written mid-word
        base_un = n_under;
        tx_write(8'hF0);
        frame_start(1'b1, 1'b1, 1'b1);
        fork
            begin
                xfer(8'h12, 8, m0);
                xfer(8'h34, 8, m1);
            end
            begin
                wait_n(40);
                tx_write(8'h0F);
            end
        join
        frame_end();
        chk("m3_rx_cnt", n_rxv, 3);
        expect_rx("m3_rx0", 8'h12);
        expect_rx("m3_rx1", 8'h34);
        chk("m3_master_rx0", m0, 8'hF0);
        chk("m3_master_rx1", m1, 8'h0F);
        chk("m3_underrun", n_under - base_un, 0);

        // mode 1, no TX data: zeros out, one underrun per word
        base_un = n_under;
        frame_start(1'b0, 1'b1, 1'b0);
        xfer(8'h66, 8, m0);
        xfer(8'h99, 8, m1);
        frame_end();
        chk("m1_rx_cnt", n_rxv, 5);
        expect_rx("m1_rx0", 8'h66);
        expect_rx("m1_rx1", 8'h99);
        chk("m1_master_rx0", m0, 8'h00);
        chk("m1_master_rx1", m1, 8'h00);
        chk("m1_underrun", n_under - base_un, 2);

        // mode 0, frame aborted after 5 bits, then a full frame realigns
        frame_start(1'b0, 1'b0, 1'b0);
        xfer(8'hFF, 5, m0);
        frame_end();
        chk("abort_no_rx", n_rxv, 5);
        frame_start(1'b0, 1'b0, 1'b0);
        xfer(8'h81, 8, m0);
        frame_end();
        chk("abort_next_rx_cnt", n_rxv, 6);
        expect_rx("abort_next_rx", 8'h81);
        chk("abort_next_master_rx", m0, 8'h00);

        // mode 2, reset asserted mid-word
        frame_start(1'b1, 1'b0, 1'b0);
        tx_write(8'h77);
        xfer(8'hC3, 4, m0);
        rstn = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_oe", miso_oe, 0);
        chk("midrst_miso", miso, 0);
        chk("midrst_tx_rdy", tx_rdy, 1);
        chk("midrst_rx_data", rx_data, 0);
        chk("midrst_rx_vld", rx_vld, 0);
        chk("midrst_underrun", under, 0);
        cs_n = 1'b1;
        wait_n(3);
        rstn = 1'b1;
        wait_n(H);
        frame_start(1'b1, 1'b0, 1'b0);
        xfer(8'h5A, 8, m0);
        frame_end();
        chk("postrst_rx_cnt", n_rxv, 7);
        expect_rx("postrst_rx", 8'h5A);
        chk("postrst_master_rx", m0, 8'h00);

`ifdef SPI_SLAVE_RX_OVERRUN_EN
        // two words with no RX consumer: second overwrites, one overrun
        rx_rdy = 1'b0;
        frame_start(1'b0, 1'b0, 1'b0);
        xfer(8'h11, 8, m0);
        xfer(8'h22, 8, m1);
        frame_end();
        chk("ovr_rx_data", rx_data, 8'h22);
        chk("ovr_rx_vld_held", rx_vld, 1);
        chk("ovr_count", n_ovr, 1);
        rx_rdy = 1'b1;
        wait_n(1);
        chk("ovr_rx_vld_cleared", rx_vld, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
